pipeline_writeback: RTL and testbench

PIPELINE_WRITEBACK -- requirements
Module: pipeline_writeback

---
 rtl/pipeline_writeback.sv | 145 ++++++++++++++
 tb/tb_pipeline_writeback.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_writeback.sv
// Writeback stage: takes one instruction from MEM, waits for load data when needed,
// and drives the register-file write port plus retire/misaligned pulses and instret.
module pipeline_writeback (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [2:0]  load_funct3_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [4:0]  write_reg_o,
  output logic [31:0] write_data_o,
  output logic        reg_write_o,
  output logic        retire_o,
  output logic        load_misaligned_o,
  output logic [31:0] instret_o
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lsb_q, lsb_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        we_q, we_d;
  logic        fault_q, fault_d;
  logic [31:0] instret_q, instret_d;

  logic accept, is_load, fault_in;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lsb,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lsb[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  assign ready_o           = (state_q != WAIT_LOAD);
  assign accept            = valid_i && ready_o;
  assign is_load           = (wb_sel_i == 2'b01);
  // Faulting loads never touch memory, so they bypass WAIT_LOAD entirely.
  assign fault_in          = is_load &&
                             ((load_funct3_i == 3'b011) || (load_funct3_i[2:1] == 2'b11) ||
                              ((load_funct3_i[1:0] == 2'b01) && addr_lsb_i[0]) ||
                              ((load_funct3_i == 3'b010) && (addr_lsb_i != 2'b00)));
  assign reg_write_o       = (state_q == WRITE) && we_q;
  assign retire_o          = (state_q == WRITE) && !fault_q;
  assign load_misaligned_o = (state_q == WRITE) && fault_q;
  assign write_reg_o       = write_reg_q;
  assign write_data_o      = write_data_q;
  assign instret_o         = instret_q;

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    rw_d         = rw_q;
    f3_d         = f3_q;
    lsb_d        = lsb_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    we_d         = we_q;
    fault_d      = fault_q;
    instret_d    = retire_o ? instret_q + 32'd1 : instret_q;
    case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          rd_d  = rd_i;
          rw_d  = reg_write_i;
          f3_d  = load_funct3_i;
          lsb_d = addr_lsb_i;
          if (is_load && !fault_in) begin
            state_d = WAIT_LOAD;
          end else begin
            state_d      = WRITE;
            write_reg_d  = rd_i;
            write_data_d = (wb_sel_i == 2'b10) ? pc_plus4_i : alu_result_i;
            we_d         = reg_write_i && (rd_i != 5'd0) && !fault_in;
            fault_d      = fault_in;
          end
        end else if (state_q == WRITE) begin
          state_d = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid_i) begin
          state_d      = WRITE;
          write_reg_d  = rd_q;
          write_data_d = extract(f3_q, lsb_q, mem_rdata_i);
          we_d         = rw_q && (rd_q != 5'd0);
          fault_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      f3_q         <= '0;
      lsb_q        <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      we_q         <= 1'b0;
      fault_q      <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      rw_q         <= rw_d;
      f3_q         <= f3_d;
      lsb_q        <= lsb_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      we_q         <= we_d;
      fault_q      <= fault_d;
      instret_q    <= instret_d;
    end
  end

endmodule

// File: tb/tb_pipeline_writeback.sv
// Directed bench for pipeline_writeback: table of single instructions plus
// hand sequences for back-to-back, load stall, reset-in-wait and instret wrap.
module tb_pipeline_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, reg_write_i, mem_rvalid_i;
  logic [4:0]  rd_i, write_reg_o;
  logic [1:0]  wb_sel_i, addr_lsb_i;
  logic [31:0] alu_result_i, pc_plus4_i, mem_rdata_i, write_data_o, instret_o;
  logic [2:0]  load_funct3_i;
  logic        reg_write_o, retire_o, load_misaligned_o;

  pipeline_writeback dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rd_i(rd_i), .reg_write_i(reg_write_i), .wb_sel_i(wb_sel_i),
    .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i),
    .load_funct3_i(load_funct3_i), .addr_lsb_i(addr_lsb_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .write_reg_o(write_reg_o), .write_data_o(write_data_o),
    .reg_write_o(reg_write_o), .retire_o(retire_o),
    .load_misaligned_o(load_misaligned_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [31:0] rdata;
    logic        exp_we;
    logic        exp_ret;
    logic        exp_mis;
    logic [31:0] exp_data;
  } vec_t;

  localparam logic [31:0] RD = 32'h80F1_7F02;
  localparam int NV = 18;

  vec_t        tv [NV];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_instret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    valid_i = 0; rd_i = 0; reg_write_i = 0; wb_sel_i = 0; alu_result_i = 0;
    pc_plus4_i = 0; load_funct3_i = 0; addr_lsb_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
    valid_i = 1; rd_i = rd; reg_write_i = 1; wb_sel_i = 2'b00; alu_result_i = val;
  endtask

  // Starts and ends one cycle after a rising edge with the DUT in IDLE.
  task automatic run_vec(input int i);
    vec_t v;
    v = tv[i];
    valid_i = 1; rd_i = v.rd; reg_write_i = v.rw; wb_sel_i = v.sel;
    alu_result_i = v.alu; pc_plus4_i = v.pc; load_funct3_i = v.f3;
    addr_lsb_i = v.lsb; mem_rdata_i = v.rdata;
    chk($sformatf("v%0d ready_idle", i), ready_o, 1);
    tick();
    valid_i = 0;
    if (v.sel == 2'b01 && !v.exp_mis) begin
      chk($sformatf("v%0d ready_wait", i), ready_o, 0);
      mem_rvalid_i = 1;
      tick();
      mem_rvalid_i = 0;
    end
    chk($sformatf("v%0d reg_write", i), reg_write_o, v.exp_we);
    chk($sformatf("v%0d retire", i), retire_o, v.exp_ret);
    chk($sformatf("v%0d misaligned", i), load_misaligned_o, v.exp_mis);
    if (v.exp_we) begin
      chk($sformatf("v%0d write_reg", i), write_reg_o, v.rd);
      chk($sformatf("v%0d write_data", i), write_data_o, v.exp_data);
    end
    if (v.exp_ret) exp_instret++;
    tick();
    chk($sformatf("v%0d retire_after", i), retire_o, 0);
    chk($sformatf("v%0d instret", i), instret_o, exp_instret);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        rd  rw sel   alu            pc             f3    lsb  rdata we ret mis data
    tv[0]  = '{5'd9,  1, 2'b00, 32'hDEAD_BEEF, 32'h0000_0104, 3'b000, 2'd0, RD, 1, 1, 0, 32'hDEAD_BEEF};
    tv[1]  = '{5'd1,  1, 2'b10, 32'h1111_1111, 32'h0000_0104, 3'b000, 2'd0, RD, 1, 1, 0, 32'h0000_0104};
    tv[2]  = '{5'd2,  1, 2'b11, 32'h0000_55AA, 32'h0000_0200, 3'b000, 2'd0, RD, 1, 1, 0, 32'h0000_55AA};
    tv[3]  = '{5'd4,  0, 2'b00, 32'h0000_0777, 32'h0000_0000, 3'b000, 2'd0, RD, 0, 1, 0, 32'h0};
    tv[4]  = '{5'd0,  1, 2'b10, 32'h0000_0000, 32'h0000_0300, 3'b000, 2'd0, RD, 0, 1, 0, 32'h0};
    tv[5]  = '{5'd10, 1, 2'b01, 32'h0,         32'h0,         3'b000, 2'd0, RD, 1, 1, 0, 32'h0000_0002};
    tv[6]  = '{5'd11, 1, 2'b01, 32'h0,         32'h0,         3'b000, 2'd1, RD, 1, 1, 0, 32'h0000_007F};
    tv[7]  = '{5'd12, 1, 2'b01, 32'h0,         32'h0,         3'b000, 2'd3, RD, 1, 1, 0, 32'hFFFF_FF80};
    tv[8]  = '{5'd13, 1, 2'b01, 32'h0,         32'h0,         3'b100, 2'd3, RD, 1, 1, 0, 32'h0000_0080};
    tv[9]  = '{5'd14, 1, 2'b01, 32'h0,         32'h0,         3'b001, 2'd2, RD, 1, 1, 0, 32'hFFFF_80F1};
    tv[10] = '{5'd15, 1, 2'b01, 32'h0,         32'h0,         3'b001, 2'd0, RD, 1, 1, 0, 32'h0000_7F02};
    tv[11] = '{5'd16, 1, 2'b01, 32'h0,         32'h0,         3'b101, 2'd2, RD, 1, 1, 0, 32'h0000_80F1};
    tv[12] = '{5'd17, 1, 2'b01, 32'h0,         32'h0,         3'b010, 2'd0, RD, 1, 1, 0, 32'h80F1_7F02};
    tv[13] = '{5'd3,  1, 2'b01, 32'h0,         32'h0,         3'b010, 2'd1, RD, 0, 0, 1, 32'h0};
    tv[14] = '{5'd18, 1, 2'b01, 32'h0,         32'h0,         3'b001, 2'd1, RD, 0, 0, 1, 32'h0};
    tv[15] = '{5'd19, 1, 2'b01, 32'h0,         32'h0,         3'b011, 2'd0, RD, 0, 0, 1, 32'h0};
    tv[16] = '{5'd20, 1, 2'b01, 32'h0,         32'h0,         3'b101, 2'd3, RD, 0, 0, 1, 32'h0};
    tv[17] = '{5'd21, 1, 2'b01, 32'h0,         32'h0,         3'b110, 2'd0, RD, 0, 0, 1, 32'h0};

    idle_inputs();
    rst_i = 1;
    tick(); tick();
    chk("rst write_reg", write_reg_o, 0);
    chk("rst write_data", write_data_o, 0);
    chk("rst reg_write", reg_write_o, 0);
    chk("rst retire", retire_o, 0);
    chk("rst misaligned", load_misaligned_o, 0);
    chk("rst instret", instret_o, 0);
    rst_i = 0;
    tick();
    chk("post_rst ready", ready_o, 1);

    // Back-to-back ALU writes.
    drive_alu(5'd5, 32'h11);
    tick();
    drive_alu(5'd6, 32'h22);
    chk("b2b w0 we", reg_write_o, 1);
    chk("b2b w0 reg", write_reg_o, 5);
    chk("b2b w0 data", write_data_o, 32'h11);
    chk("b2b w0 ready", ready_o, 1);
    tick();
    valid_i = 0;
    chk("b2b w1 we", reg_write_o, 1);
    chk("b2b w1 reg", write_reg_o, 6);
    chk("b2b w1 data", write_data_o, 32'h22);
    tick();
    chk("b2b idle we", reg_write_o, 0);
    chk("b2b instret", instret_o, 2);
    exp_instret = 2;

    // rvalid in IDLE must be ignored.
    mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_rvalid_i = 0;
    chk("idle rvalid we", reg_write_o, 0);
    chk("idle rvalid retire", retire_o, 0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // LB stall: rvalid three cycles after acceptance; valid_i ignored while waiting.
    valid_i = 1; rd_i = 7; reg_write_i = 1; wb_sel_i = 2'b01;
    load_funct3_i = 3'b000; addr_lsb_i = 2'd2;
    tick();
    rd_i = 9; wb_sel_i = 2'b00; alu_result_i = 32'h1234;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("lb stall%0d ready", c), ready_o, 0);
      chk($sformatf("lb stall%0d we", c), reg_write_o, 0);
      tick();
    end
    valid_i = 0;
    chk("lb stall2 ready", ready_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h0080_FF00;
    tick();
    mem_rvalid_i = 0;
    chk("lb we", reg_write_o, 1);
    chk("lb reg", write_reg_o, 7);
    chk("lb data", write_data_o, 32'hFFFF_FF80);
    exp_instret++;
    tick();
    chk("lb instret", instret_o, exp_instret);

    // Reset while waiting for load data discards it.
    valid_i = 1; rd_i = 8; reg_write_i = 1; wb_sel_i = 2'b01;
    load_funct3_i = 3'b010; addr_lsb_i = 2'd0;
    tick();
    valid_i = 0;
    chk("rstwait ready_wait", ready_o, 0);
    rst_i = 1;
    tick();
    rst_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    chk("rstwait ready", ready_o, 1);
    tick();
    mem_rvalid_i = 0;
    chk("rstwait we", reg_write_o, 0);
    chk("rstwait retire", retire_o, 0);
    chk("rstwait instret", instret_o, 0);
    chk("rstwait write_reg", write_reg_o, 0);

    // instret wrap.
    force dut.instret_q = 32'hFFFF_FFFF;
    tick();
    release dut.instret_q;
    chk("wrap preload", instret_o, 32'hFFFF_FFFF);
    exp_instret = 32'hFFFF_FFFF;
    run_vec(0);
    chk("wrap zero", instret_o, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
